// File: rtl/adxl362_txn_sched.sv
// ADXL362 transaction scheduler: power-up configuration, periodic X/Y/Z polling and one
// host register port, all sharing a single Mode-0 SPI byte engine under one CS owner.
module adxl362_txn_sched #(
  parameter int CS_SETUP    = 2,
  parameter int CS_HOLD     = 2,
  parameter int INIT_WAIT   = 50000,
  parameter int POLL_PERIOD = 1000000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       host_req_i,
  input  logic       host_we_i,
  input  logic [7:0] host_addr_i,
  input  logic [7:0] host_wdata_i,
  output logic       host_ack_o,
  output logic [7:0] host_rdata_o,
  output logic       byte_start_o,
  output logic [7:0] byte_data_o,
  input  logic       byte_done_i,
  input  logic [7:0] byte_rx_i,
  output logic       spi_cs_n_o,
  output logic       init_done_o,
  output logic [7:0] x_data_o,
  output logic [7:0] y_data_o,
  output logic [7:0] z_data_o,
  output logic       sample_valid_o,
  output logic       busy_o,
  output logic [2:0] dbg_state_o
);
  // Handshakes: host_req_i is a level held until the 1-cycle host_ack_o; byte_start_o
  // launches one byte and no other starts until the cycle after its byte_done_i.

  typedef enum logic [2:0] {
    S_INIT_SRST, S_INIT_WAIT, S_INIT_PWR, S_IDLE, S_CS_SETUP, S_XFER, S_CS_HOLD
  } state_t;

  typedef enum logic [1:0] {K_SRST, K_PWR, K_POLL, K_HOST} kind_t;

  localparam int CW = $clog2(INIT_WAIT + CS_SETUP + CS_HOLD + 1);
  localparam int PW = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
  localparam logic [CW-1:0] SETUP_LAST = CW'(CS_SETUP - 1);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(CS_HOLD - 1);
  localparam logic [CW-1:0] WAIT_LAST  = CW'(INIT_WAIT - 1);
  localparam logic [PW-1:0] TIMER_LAST = PW'(POLL_PERIOD - 1);
  localparam logic [7:0]    CMD_WR     = 8'h0A;
  localparam logic [7:0]    CMD_RD     = 8'h0B;

  state_t        state_q, state_d;
  kind_t         kind_q, kind_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] timer_q, timer_d;
  logic [2:0]    idx_q, idx_d, last_idx_q, last_idx_d;
  logic          outst_q, outst_d;
  logic          we_q, we_d;
  logic [7:0]    addr_q, addr_d, wdata_q, wdata_d;
  logic [7:0]    rx0_q, rx0_d, rx1_q, rx1_d, rx2_q, rx2_d;
  logic [7:0]    x_q, x_d, y_q, y_d, z_q, z_d, rdata_q, rdata_d;
  logic          host_ack_q, host_ack_d, sample_valid_q, sample_valid_d;
  logic          init_done_q, init_done_d, poll_pend_q, poll_pend_d;
  logic          rr_poll_q, rr_poll_d;
  logic          cs_n_q, busy_q;
  logic          byte_start, host_ok, pick_poll, in_txn_d;
  logic [7:0]    cur_byte;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= S_INIT_SRST;
      kind_q         <= K_SRST;
      cnt_q          <= '0;
      timer_q        <= '0;
      idx_q          <= '0;
      last_idx_q     <= '0;
      outst_q        <= 1'b0;
      we_q           <= 1'b0;
      addr_q         <= '0;
      wdata_q        <= '0;
      rx0_q          <= '0;
      rx1_q          <= '0;
      rx2_q          <= '0;
      x_q            <= '0;
      y_q            <= '0;
      z_q            <= '0;
      rdata_q        <= '0;
      host_ack_q     <= 1'b0;
      sample_valid_q <= 1'b0;
      init_done_q    <= 1'b0;
      poll_pend_q    <= 1'b0;
      rr_poll_q      <= 1'b0;
      cs_n_q         <= 1'b1;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      kind_q         <= kind_d;
      cnt_q          <= cnt_d;
      timer_q        <= timer_d;
      idx_q          <= idx_d;
      last_idx_q     <= last_idx_d;
      outst_q        <= outst_d;
      we_q           <= we_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      rx0_q          <= rx0_d;
      rx1_q          <= rx1_d;
      rx2_q          <= rx2_d;
      x_q            <= x_d;
      y_q            <= y_d;
      z_q            <= z_d;
      rdata_q        <= rdata_d;
      host_ack_q     <= host_ack_d;
      sample_valid_q <= sample_valid_d;
      init_done_q    <= init_done_d;
      poll_pend_q    <= poll_pend_d;
      rr_poll_q      <= rr_poll_d;
      cs_n_q         <= ~in_txn_d;
      busy_q         <= (state_d != S_IDLE);
    end
  end

  always_comb begin
    state_d        = state_q;
    kind_d         = kind_q;
    cnt_d          = cnt_q;
    timer_d        = timer_q;
    idx_d          = idx_q;
    last_idx_d     = last_idx_q;
    outst_d        = outst_q;
    we_d           = we_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    rx0_d          = rx0_q;
    rx1_d          = rx1_q;
    rx2_d          = rx2_q;
    x_d            = x_q;
    y_d            = y_q;
    z_d            = z_q;
    rdata_d        = rdata_q;
    host_ack_d     = 1'b0;
    sample_valid_d = 1'b0;
    init_done_d    = init_done_q;
    poll_pend_d    = poll_pend_q;
    rr_poll_d      = rr_poll_q;
    byte_start     = 1'b0;
    // The ack cycle is excluded so a host dropping req on seeing ack is not re-served.
    host_ok        = host_req_i && init_done_q && !host_ack_q;
    pick_poll      = 1'b0;

    unique case (state_q)
      S_INIT_SRST, S_INIT_PWR: begin
        kind_d     = (state_q == S_INIT_SRST) ? K_SRST : K_PWR;
        we_d       = 1'b1;
        addr_d     = (state_q == S_INIT_SRST) ? 8'h1F : 8'h2D;
        wdata_d    = (state_q == S_INIT_SRST) ? 8'h52 : 8'h02;
        last_idx_d = 3'd2;
        state_d    = S_CS_SETUP;
        cnt_d      = '0;
        idx_d      = '0;
        outst_d    = 1'b0;
      end
      S_INIT_WAIT: begin
        if (cnt_q == WAIT_LAST) begin
          state_d = S_INIT_PWR;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_IDLE: begin
        // Priority only flips on contested grants; a lone requester is served directly.
        if (host_ok && poll_pend_q) begin
          pick_poll = rr_poll_q;
          rr_poll_d = ~rr_poll_q;
        end else begin
          pick_poll = poll_pend_q;
        end
        if (host_ok || poll_pend_q) begin
          state_d = S_CS_SETUP;
          cnt_d   = '0;
          idx_d   = '0;
          outst_d = 1'b0;
          if (pick_poll) begin
            kind_d      = K_POLL;
            we_d        = 1'b0;
            addr_d      = 8'h08;
            wdata_d     = 8'h00;
            last_idx_d  = 3'd4;
            poll_pend_d = 1'b0;
          end else begin
            kind_d     = K_HOST;
            we_d       = host_we_i;
            addr_d     = host_addr_i;
            wdata_d    = host_wdata_i;
            last_idx_d = 3'd2;
          end
        end
      end
      S_CS_SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          state_d = S_XFER;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_XFER: begin
        if (!outst_q) begin
          byte_start = 1'b1;
          outst_d    = 1'b1;
        end else if (byte_done_i) begin
          outst_d = 1'b0;
          case (idx_q)
            3'd2:    rx0_d = byte_rx_i;
            3'd3:    rx1_d = byte_rx_i;
            3'd4:    rx2_d = byte_rx_i;
            default: ;
          endcase
          if (idx_q == last_idx_q) begin
            state_d = S_CS_HOLD;
            cnt_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      S_CS_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          cnt_d   = '0;
          state_d = S_IDLE;
          unique case (kind_q)
            K_SRST: state_d = S_INIT_WAIT;
            K_PWR:  init_done_d = 1'b1;
            K_POLL: begin
              sample_valid_d = 1'b1;
              x_d = rx0_q;
              y_d = rx1_q;
              z_d = rx2_q;
            end
            K_HOST: begin
              host_ack_d = 1'b1;
              if (!we_q) rdata_d = rx0_q;
            end
          endcase
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_INIT_SRST;
    endcase

    if (init_done_q) begin
      if (timer_q == TIMER_LAST) begin
        timer_d     = '0;
        poll_pend_d = 1'b1;
      end else begin
        timer_d = timer_q + 1'b1;
      end
    end
  end

  always_comb begin
    cur_byte = 8'h00;
    case (idx_q)
      3'd0:    cur_byte = we_q ? CMD_WR : CMD_RD;
      3'd1:    cur_byte = addr_q;
      default: cur_byte = we_q ? wdata_q : 8'h00;
    endcase
  end

  assign in_txn_d       = (state_d == S_CS_SETUP) || (state_d == S_XFER) || (state_d == S_CS_HOLD);
  assign byte_start_o   = byte_start;
  assign byte_data_o    = byte_start ? cur_byte : 8'h00;
  assign spi_cs_n_o     = cs_n_q;
  assign busy_o         = busy_q;
  assign host_ack_o     = host_ack_q;
  assign host_rdata_o   = rdata_q;
  assign init_done_o    = init_done_q;
  assign sample_valid_o = sample_valid_q;
  assign x_data_o       = x_q;
  assign y_data_o       = y_q;
  assign z_data_o       = z_q;
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_adxl362_txn_sched.sv
// Directed bench for adxl362_txn_sched with a behavioural byte engine that answers
// each byte_start with byte_done 8 cycles later.
module tb_adxl362_txn_sched;
  localparam int CS_SETUP    = 2;
  localparam int CS_HOLD     = 2;
  localparam int INIT_WAIT   = 40;
  localparam int POLL_PERIOD = 400;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       host_req = 1'b0;
  logic       host_we = 1'b0;
  logic [7:0] host_addr = 8'h00;
  logic [7:0] host_wdata = 8'h00;
  logic       byte_done = 1'b0;
  logic [7:0] byte_rx = 8'h00;
  logic       host_ack, byte_start, spi_cs_n, init_done, sample_valid, busy;
  logic [7:0] host_rdata, byte_data, x_data, y_data, z_data;
  logic [2:0] dbg_state;

  adxl362_txn_sched #(
    .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD), .INIT_WAIT(INIT_WAIT), .POLL_PERIOD(POLL_PERIOD)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .host_req_i(host_req), .host_we_i(host_we), .host_addr_i(host_addr),
    .host_wdata_i(host_wdata), .host_ack_o(host_ack), .host_rdata_o(host_rdata),
    .byte_start_o(byte_start), .byte_data_o(byte_data),
    .byte_done_i(byte_done), .byte_rx_i(byte_rx),
    .spi_cs_n_o(spi_cs_n), .init_done_o(init_done),
    .x_data_o(x_data), .y_data_o(y_data), .z_data_o(z_data),
    .sample_valid_o(sample_valid), .busy_o(busy), .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  // Engine model and event monitor, evaluated 1 time unit after each rising edge.
  int         cyc = 0;
  logic [7:0] log_q[$];
  int         win_q[$];
  int         start_cyc_q[$];
  int         done_cyc_q[$];
  int         fall_q[$];
  int         rise_q[$];
  logic [7:0] rx_tab [5];
  int         eng_cnt = 0, eng_idx = 0, win_id = 0, win_byte = 0, cs_viol = 0;
  int         n_init_rise = 0, n_sv = 0, n_ack = 0, init_cyc = 0;
  logic       prev_cs = 1'b1, prev_init = 1'b0;

  initial begin
    for (int i = 0; i < 5; i++) rx_tab[i] = 8'h00;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      byte_done = 1'b0;
      if (prev_cs && !spi_cs_n) begin
        win_id++;
        win_byte = 0;
        fall_q.push_back(cyc);
      end
      if (!prev_cs && spi_cs_n) rise_q.push_back(cyc);
      prev_cs = spi_cs_n;
      if (rst) begin
        eng_cnt = 0;
      end else if (eng_cnt > 0) begin
        eng_cnt--;
        if (eng_cnt == 0) begin
          byte_done = 1'b1;
          byte_rx = rx_tab[eng_idx];
          done_cyc_q.push_back(cyc);
        end
      end
      if (byte_start) begin
        if (spi_cs_n || eng_cnt != 0) cs_viol++;
        log_q.push_back(byte_data);
        win_q.push_back(win_id);
        start_cyc_q.push_back(cyc);
        eng_idx = (win_byte < 5) ? win_byte : 4;
        win_byte++;
        eng_cnt = 8;
      end
      if (init_done && !prev_init) begin
        n_init_rise++;
        init_cyc = cyc;
      end
      prev_init = init_done;
      if (sample_valid) n_sv++;
      if (host_ack) n_ack++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t, limit 2000000", $time);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [63:0] pack_log(int base, int n);
    logic [63:0] r = '0;
    for (int i = 0; i < n; i++)
      if (base + i < log_q.size()) r = (r << 8) | 64'(log_q[base + i]);
    return r;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    host_req = 1'b0;
    repeat (4) tick();
    n_total++;
    if (spi_cs_n !== 1'b1) $display("FAIL rst_cs_n: got %b want 1", spi_cs_n); else n_pass++;
    n_total++;
    if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else n_pass++;
    n_total++;
    if (init_done !== 1'b0) $display("FAIL rst_init_done: got %b want 0", init_done); else n_pass++;
    n_total++;
    if ({byte_start, host_ack, sample_valid} !== 3'b000)
      $display("FAIL rst_pulses: got %b want 000", {byte_start, host_ack, sample_valid});
    else n_pass++;
    n_total++;
    if ({x_data, y_data, z_data, host_rdata} !== 32'h0)
      $display("FAIL rst_data: got %h want 0", {x_data, y_data, z_data, host_rdata});
    else n_pass++;
  endtask

  task automatic test_init();
    int base = log_q.size();
    int fb = fall_q.size();
    int rb = rise_q.size();
    int db = done_cyc_q.size();
    int ir = n_init_rise;
    bit got = 0;
    rst = 1'b0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (init_done) begin got = 1; break; end
    end
    n_total++;
    if (!got) $display("FAIL init_timeout: init_done got 0 want 1 within 400 cycles"); else n_pass++;
    n_total++;
    if (log_q.size() != base + 6 || pack_log(base, 6) !== 64'h0A1F520A2D02)
      $display("FAIL init_bytes: got %h (%0d bytes) want 0a1f520a2d02",
               pack_log(base, 6), log_q.size() - base);
    else n_pass++;
    n_total++;
    if (win_q.size() < base + 6 || win_q[base] != win_q[base+2] || win_q[base+3] != win_q[base+5]
        || win_q[base+3] != win_q[base] + 1)
      $display("FAIL init_windows: got byte windows not split 3+3 want two CS windows");
    else n_pass++;
    n_total++;
    if (fall_q.size() < fb + 2 || rise_q.size() < rb + 2 || fall_q[fb+1] - rise_q[rb] < INIT_WAIT)
      $display("FAIL init_gap: got %0d idle cycles want >= %0d",
               fall_q[fb+1] - rise_q[rb], INIT_WAIT);
    else n_pass++;
    n_total++;
    if (start_cyc_q[base] - fall_q[fb] != CS_SETUP)
      $display("FAIL cs_setup: got %0d want %0d", start_cyc_q[base] - fall_q[fb], CS_SETUP);
    else n_pass++;
    n_total++;
    if (done_cyc_q.size() < db + 3 || rise_q[rb] - done_cyc_q[db+2] != CS_HOLD + 1)
      $display("FAIL cs_hold: got %0d want %0d", rise_q[rb] - done_cyc_q[db+2], CS_HOLD + 1);
    else n_pass++;
    n_total++;
    if (init_cyc != rise_q[rb+1])
      $display("FAIL init_done_time: got cycle %0d want %0d", init_cyc, rise_q[rb+1]);
    else n_pass++;
    repeat (5) tick();
    n_total++;
    if (n_init_rise - ir != 1 || init_done !== 1'b1)
      $display("FAIL init_once: got %0d rises want 1", n_init_rise - ir);
    else n_pass++;
  endtask

  task automatic test_host_read();
    int base = log_q.size();
    int a0 = n_ack;
    int rb = rise_q.size();
    bit got = 0;
    logic [7:0] rd = 8'h00;
    int ack_at = 0;
    rx_tab[2] = 8'hAD;
    host_we = 1'b0;
    host_addr = 8'h00;
    host_req = 1'b1;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (host_ack) begin
        got = 1;
        rd = host_rdata;
        ack_at = cyc;
        host_req = 1'b0;
        break;
      end
    end
    host_req = 1'b0;
    n_total++;
    if (!got) $display("FAIL host_rd_timeout: host_ack got 0 want 1 within 200 cycles"); else n_pass++;
    n_total++;
    if (rd !== 8'hAD) $display("FAIL host_rdata: got %h want ad", rd); else n_pass++;
    n_total++;
    if (log_q.size() != base + 3 || pack_log(base, 3) !== 64'h0B0000)
      $display("FAIL host_rd_bytes: got %h want 0b0000", pack_log(base, 3));
    else n_pass++;
    n_total++;
    if (rise_q.size() <= rb || ack_at != rise_q[rb])
      $display("FAIL host_ack_time: got cycle %0d want cycle of CS rise", ack_at);
    else n_pass++;
    tick();
    n_total++;
    if (host_ack !== 1'b0 || host_rdata !== 8'hAD)
      $display("FAIL host_ack_width: got ack=%b rdata=%h want 0/ad", host_ack, host_rdata);
    else n_pass++;
    repeat (5) tick();
    n_total++;
    if (n_ack - a0 != 1) $display("FAIL host_ack_count: got %0d want 1", n_ack - a0); else n_pass++;
    rx_tab[2] = 8'h00;
  endtask

  task automatic test_poll();
    int base = log_q.size();
    int fb = fall_q.size();
    int s0 = n_sv;
    bit got = 0;
    rx_tab[2] = 8'h11;
    rx_tab[3] = 8'h22;
    rx_tab[4] = 8'h33;
    for (int i = 0; i < POLL_PERIOD + 200; i++) begin
      tick();
      if (sample_valid) begin got = 1; break; end
    end
    n_total++;
    if (!got) $display("FAIL poll_timeout: sample_valid got 0 want 1"); else n_pass++;
    n_total++;
    if (fall_q.size() <= fb || fall_q[fb] != init_cyc + POLL_PERIOD + 1)
      $display("FAIL poll_start: got cycle %0d want %0d", fall_q[fb], init_cyc + POLL_PERIOD + 1);
    else n_pass++;
    n_total++;
    if (log_q.size() != base + 5 || pack_log(base, 5) !== 64'h0B08000000)
      $display("FAIL poll_bytes: got %h want 0b08000000", pack_log(base, 5));
    else n_pass++;
    n_total++;
    if ({x_data, y_data, z_data} !== 24'h112233)
      $display("FAIL poll_xyz: got %h want 112233", {x_data, y_data, z_data});
    else n_pass++;
    tick();
    n_total++;
    if (sample_valid !== 1'b0) $display("FAIL sv_width: got %b want 0", sample_valid); else n_pass++;
    repeat (5) tick();
    n_total++;
    if (n_sv - s0 != 1) $display("FAIL sv_count: got %0d want 1", n_sv - s0); else n_pass++;
  endtask

  task automatic test_back_to_back_tie();
    int base, a0, s0;
    bit done_ok;
    rx_tab[2] = 8'h44;
    rx_tab[3] = 8'h55;
    rx_tab[4] = 8'h66;
    for (int k = 2; k <= 3; k++) begin
      while (cyc < init_cyc + k * POLL_PERIOD) tick();
      base = log_q.size();
      a0 = n_ack;
      s0 = n_sv;
      host_we = 1'b1;
      host_addr = 8'h2C;
      host_wdata = (k == 2) ? 8'h13 : 8'h14;
      host_req = 1'b1;
      done_ok = 0;
      for (int i = 0; i < 300; i++) begin
        tick();
        if (host_ack) host_req = 1'b0;
        if (n_ack > a0 && n_sv > s0) begin done_ok = 1; break; end
      end
      host_req = 1'b0;
      n_total++;
      if (!done_ok) $display("FAIL tie%0d_timeout: ack=%0d sv=%0d want 1/1", k, n_ack - a0, n_sv - s0);
      else n_pass++;
      n_total++;
      if (k == 2 && (log_q.size() != base + 8 || pack_log(base, 8) !== 64'h0A2C130B08000000))
        $display("FAIL tie1_order: got %h want 0a2c130b08000000", pack_log(base, 8));
      else if (k == 3 && (log_q.size() != base + 8 || pack_log(base, 8) !== 64'h0B080000000A2C14))
        $display("FAIL tie2_order: got %h want 0b080000000a2c14", pack_log(base, 8));
      else n_pass++;
    end
    repeat (4) tick();
    n_total++;
    if ({x_data, y_data, z_data} !== 24'h445566)
      $display("FAIL tie_xyz: got %h want 445566", {x_data, y_data, z_data});
    else n_pass++;
  endtask

  task automatic test_reset_mid_poll();
    int base = log_q.size();
    int s0 = n_sv;
    int ir = n_init_rise;
    bit got = 0;
    for (int i = 0; i < 600; i++) begin
      tick();
      if (log_q.size() >= base + 2) begin got = 1; break; end
    end
    n_total++;
    if (!got) $display("FAIL mid_poll_timeout: got %0d bytes want 2", log_q.size() - base); else n_pass++;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_total++;
    if (spi_cs_n !== 1'b1 || byte_start !== 1'b0)
      $display("FAIL mid_rst_cs: got cs_n=%b start=%b want 1/0", spi_cs_n, byte_start);
    else n_pass++;
    n_total++;
    if ({x_data, y_data, z_data} !== 24'h0)
      $display("FAIL mid_rst_xyz: got %h want 000000", {x_data, y_data, z_data});
    else n_pass++;
    got = 0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (init_done) begin got = 1; break; end
    end
    n_total++;
    if (!got || log_q.size() != base + 8 || pack_log(base, 8) !== 64'h0B080A1F520A2D02)
      $display("FAIL restart_bytes: got %h want 0b080a1f520a2d02", pack_log(base, 8));
    else n_pass++;
    n_total++;
    if (n_sv != s0 || n_init_rise - ir != 1)
      $display("FAIL restart_pulses: got sv=%0d init=%0d want 0/1", n_sv - s0, n_init_rise - ir);
    else n_pass++;
  endtask

  task automatic test_host_before_init();
    int base, fb, a0;
    bit got = 0;
    rst = 1'b1;
    host_we = 1'b1;
    host_addr = 8'h20;
    host_wdata = 8'h55;
    host_req = 1'b1;
    repeat (3) tick();
    base = log_q.size();
    fb = fall_q.size();
    a0 = n_ack;
    n_total++;
    if (host_ack !== 1'b0 || init_done !== 1'b0)
      $display("FAIL early_ack: got ack=%b init=%b want 0/0", host_ack, init_done);
    else n_pass++;
    rst = 1'b0;
    for (int i = 0; i < 600; i++) begin
      tick();
      if (host_ack) begin got = 1; host_req = 1'b0; break; end
    end
    host_req = 1'b0;
    n_total++;
    if (!got) $display("FAIL early_host_timeout: host_ack got 0 want 1"); else n_pass++;
    n_total++;
    if (log_q.size() != base + 9 || pack_log(base, 6) !== 64'h0A1F520A2D02
        || pack_log(base + 6, 3) !== 64'h0A2055)
      $display("FAIL early_host_bytes: got %h %h want 0a1f520a2d02 0a2055",
               pack_log(base, 6), pack_log(base + 6, 3));
    else n_pass++;
    n_total++;
    if (fall_q.size() < fb + 3 || fall_q[fb+2] != init_cyc + 1)
      $display("FAIL early_host_start: got cycle %0d want %0d", fall_q[fb+2], init_cyc + 1);
    else n_pass++;
    repeat (20) tick();
    n_total++;
    if (n_ack - a0 != 1) $display("FAIL early_ack_count: got %0d want 1", n_ack - a0); else n_pass++;
  endtask

  task automatic test_cs_framing();
    bit ok = (fall_q.size() == rise_q.size());
    for (int i = 0; i + 1 < fall_q.size() && ok; i++)
      if (fall_q[i+1] <= rise_q[i]) ok = 0;
    n_total++;
    if (!ok) $display("FAIL cs_overlap: got falls=%0d rises=%0d or no high gap want disjoint",
                      fall_q.size(), rise_q.size());
    else n_pass++;
    n_total++;
    if (cs_viol != 0) $display("FAIL byte_protocol: got %0d violations want 0", cs_viol); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_init();
    test_host_read();
    test_poll();
    test_back_to_back_tie();
    test_reset_mid_poll();
    test_host_before_init();
    test_cs_framing();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
